// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR scan controller.
package sar_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SAMPLE, S_CONVERT, S_ACCUM, S_DONE
  } sar_state_e;

  localparam int MaxCh  = 16;
  localparam int MaxChW = 4;

  typedef struct packed {
    logic              found;
    logic [MaxChW-1:0] idx;
  } ch_pick_t;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit of mask at or above ptr; ptr may equal MaxCh (nothing left).
  function automatic ch_pick_t next_ch(input logic [MaxCh-1:0] mask,
                                       input logic [MaxChW:0]  ptr);
    ch_pick_t r;
    r = '0;
    for (int i = MaxCh-1; i >= 0; i--)
      if (mask[i] && (5'(i) >= ptr)) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    return r;
  endfunction

endpackage

// File: rtl/sar_scan_ctrl_if.sv
// Analog front-end and result handshake of the SAR scan controller.
interface sar_scan_ctrl_if #(
  parameter int Width = 6,
  parameter int NumCh = 4
);
  localparam int ChW = sar_pkg::ch_w(NumCh);

  logic             start_i;
  logic             continuous_i;
  logic [NumCh-1:0] ch_en_i;
  logic             cmp_i;
  logic             sample_o;
  logic [Width-1:0] dac_o;
  logic [ChW-1:0]   ch_sel_o;
  logic [Width-1:0] result_o;
  logic [ChW-1:0]   result_ch_o;
  logic             valid_o;
  logic             eoc_o;
  logic             busy_o;

  modport master (
    input  start_i, continuous_i, ch_en_i, cmp_i,
    output sample_o, dac_o, ch_sel_o, result_o, result_ch_o, valid_o, eoc_o, busy_o
  );

  modport slave (
    output start_i, continuous_i, ch_en_i, cmp_i,
    input  sample_o, dac_o, ch_sel_o, result_o, result_ch_o, valid_o, eoc_o, busy_o
  );
endinterface

// File: rtl/sar_bs_core.sv
// Binary-search engine: one trial bit per cycle, MSB first, starting the cycle after go.
module sar_bs_core #(
  parameter int Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             go,
  input  logic             cmp_i,
  output logic [Width-1:0] dac,
  output logic [Width-1:0] code,
  output logic             done
);
  logic             active;
  logic [Width-1:0] kept;
  logic [Width-1:0] trial;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active <= 1'b0;
      kept   <= '0;
      trial  <= '0;
      code   <= '0;
    end else if (go) begin
      active <= 1'b1;
      kept   <= '0;
      trial  <= {1'b1, {(Width-1){1'b0}}};
    end else if (active) begin
      if (cmp_i) kept <= kept | trial;
      trial <= trial >> 1;
      if (trial[0]) begin
        active <= 1'b0;
        code   <= cmp_i ? (kept | trial) : kept;
      end
    end
  end

  assign dac  = active ? (kept | trial) : '0;
  // High during the last trial cycle; code is final on the following cycle.
  assign done = active & trial[0];

endmodule

// File: rtl/sar_scan_ctrl.sv
// Round-robin multi-channel SAR controller with oversampling and continuous scan.
module sar_scan_ctrl
  import sar_pkg::*;
#(
  parameter int Width        = 6,
  parameter int NumCh        = 4,
  parameter int SampleCycles = 2,
  parameter int AvgLog2      = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  sar_scan_ctrl_if.master bus
);
  localparam int ChW   = ch_w(NumCh);
  localparam int AccW  = Width + AvgLog2;
  localparam int SampW = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;
  localparam int AvgW  = AvgLog2 + 1;
  localparam logic [SampW-1:0] SampLast = SampW'(SampleCycles - 1);
  localparam logic [AvgW-1:0]  AvgLast  = AvgW'((1 << AvgLog2) - 1);

  sar_state_e       state;
  logic [NumCh-1:0] mask;
  logic [ChW-1:0]   cur_ch;
  logic [SampW-1:0] samp_cnt;
  logic [AvgW-1:0]  avg_cnt;
  logic [AccW-1:0]  acc;
  logic             sample_q, valid_q, eoc_q, busy_q;
  logic [ChW-1:0]   ch_sel_q, result_ch_q;
  logic [Width-1:0] result_q;

  logic             go, core_done;
  logic [Width-1:0] core_dac, core_code;
  logic [AccW-1:0]  acc_sum;
  ch_pick_t         start_pick, wrap_pick, next_pick;

  always_comb begin
    start_pick = next_ch(MaxCh'(bus.ch_en_i), '0);
    wrap_pick  = next_ch(MaxCh'(mask), '0);
    next_pick  = next_ch(MaxCh'(mask), 5'(cur_ch) + 5'd1);
    go         = (state == S_SAMPLE) && (samp_cnt == SampLast);
    acc_sum    = acc + AccW'(core_code);
  end

  sar_bs_core #(.Width(Width)) u_core (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .go     (go),
    .cmp_i  (bus.cmp_i),
    .dac    (core_dac),
    .code   (core_code),
    .done   (core_done)
  );

  // Channel select is computed on the way into SELECT so ch_sel_o is valid there.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      mask        <= '0;
      cur_ch      <= '0;
      samp_cnt    <= '0;
      avg_cnt     <= '0;
      acc         <= '0;
      sample_q    <= 1'b0;
      valid_q     <= 1'b0;
      eoc_q       <= 1'b0;
      busy_q      <= 1'b0;
      ch_sel_q    <= '0;
      result_ch_q <= '0;
      result_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      eoc_q   <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.start_i && |bus.ch_en_i) begin
          mask     <= bus.ch_en_i;
          cur_ch   <= start_pick.idx[ChW-1:0];
          ch_sel_q <= start_pick.idx[ChW-1:0];
          busy_q   <= 1'b1;
          state    <= S_SELECT;
        end
        S_SELECT: begin
          acc      <= '0;
          avg_cnt  <= '0;
          samp_cnt <= '0;
          sample_q <= 1'b1;
          state    <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (go) begin
            sample_q <= 1'b0;
            state    <= S_CONVERT;
          end else begin
            samp_cnt <= samp_cnt + SampW'(1);
          end
        end
        S_CONVERT: if (core_done) state <= S_ACCUM;
        S_ACCUM: begin
          acc     <= acc_sum;
          avg_cnt <= avg_cnt + AvgW'(1);
          if (avg_cnt == AvgLast) begin
            valid_q     <= 1'b1;
            eoc_q       <= !next_pick.found;
            result_q    <= Width'(acc_sum >> AvgLog2);
            result_ch_q <= cur_ch;
            state       <= S_DONE;
          end else begin
            samp_cnt <= '0;
            sample_q <= 1'b1;
            state    <= S_SAMPLE;
          end
        end
        S_DONE: begin
          if (next_pick.found) begin
            cur_ch   <= next_pick.idx[ChW-1:0];
            ch_sel_q <= next_pick.idx[ChW-1:0];
            state    <= S_SELECT;
          end else if (bus.continuous_i) begin
            cur_ch   <= wrap_pick.idx[ChW-1:0];
            ch_sel_q <= wrap_pick.idx[ChW-1:0];
            state    <= S_SELECT;
          end else begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.sample_o    = sample_q;
  assign bus.dac_o       = core_dac;
  assign bus.ch_sel_o    = ch_sel_q;
  assign bus.result_o    = result_q;
  assign bus.result_ch_o = result_ch_q;
  assign bus.valid_o     = valid_q;
  assign bus.eoc_o       = eoc_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed bench for sar_scan_ctrl: ideal comparator models, vector table plus corner sequences.
module tb_sar_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sar_scan_ctrl_if #(.Width(6), .NumCh(4)) bus0();
  sar_scan_ctrl_if #(.Width(6), .NumCh(4)) bus1();

  sar_scan_ctrl #(.Width(6), .NumCh(4), .SampleCycles(2), .AvgLog2(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  sar_scan_ctrl #(.Width(6), .NumCh(4), .SampleCycles(2), .AvgLog2(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1));

  // Per-channel input voltage as an ideal 6-bit code.
  logic [3:0][5:0] vin;
  assign bus0.cmp_i = (vin[bus0.ch_sel_o] >= bus0.dac_o);

  // Averaging instance sees 10,11,10,11 on successive conversions.
  int conv1 = 0;
  logic [5:0] vin1;
  always @(posedge bus1.sample_o) conv1++;
  assign vin1 = conv1[0] ? 6'd10 : 6'd11;
  assign bus1.cmp_i = (vin1 >= bus1.dac_o);

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]      mask;
    logic [3:0][5:0] vin;
    int              n;
    logic [3:0][1:0] ch;
    logic [3:0][5:0] res;
  } vec_t;
  vec_t tbl[5];

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   bus0.busy_o, 0);
    check({tag, "_valid"},  bus0.valid_o, 0);
    check({tag, "_eoc"},    bus0.eoc_o, 0);
    check({tag, "_sample"}, bus0.sample_o, 0);
    check({tag, "_dac"},    bus0.dac_o, 0);
    check({tag, "_chsel"},  bus0.ch_sel_o, 0);
    check({tag, "_res"},    bus0.result_o, 0);
    check({tag, "_resch"},  bus0.result_ch_o, 0);
  endtask

  task automatic pulse_start0();
    @(negedge clk); bus0.start_i = 1'b1;
    @(negedge clk); bus0.start_i = 1'b0;
  endtask

  task automatic run_vec(input int k);
    int nv, cyc, first;
    bit fin, saw_busy;
    vin = tbl[k].vin;
    bus0.ch_en_i = tbl[k].mask;
    bus0.continuous_i = 1'b0;
    pulse_start0();
    nv = 0; cyc = 0; first = 0; fin = 0; saw_busy = 0;
    while (!fin && cyc < 100) begin
      @(negedge clk); cyc++;
      if (bus0.busy_o) saw_busy = 1;
      if (bus0.valid_o) begin
        if (nv == 0) first = cyc;
        if (nv < tbl[k].n) begin
          check($sformatf("v%0d_ch%0d", k, nv), bus0.result_ch_o, tbl[k].ch[nv]);
          check($sformatf("v%0d_res%0d", k, nv), bus0.result_o, tbl[k].res[nv]);
          check($sformatf("v%0d_eoc%0d", k, nv), bus0.eoc_o, nv == tbl[k].n - 1);
        end else begin
          check($sformatf("v%0d_extra_valid", k), nv, tbl[k].n);
        end
        if (bus0.eoc_o) fin = 1;
        nv++;
      end
    end
    check($sformatf("v%0d_nvalid", k), nv, tbl[k].n);
    if (tbl[k].n > 0) begin
      check($sformatf("v%0d_latency", k), first + 1, 11);
      @(negedge clk);
      check($sformatf("v%0d_busy_after", k), bus0.busy_o, 0);
    end else begin
      check($sformatf("v%0d_busy_mask0", k), saw_busy, 0);
    end
  endtask

  initial begin
    logic [5:0] dseq [6];
    int nv, neoc, cyc, first, nidle;
    bit fin;

    dseq = '{6'h20, 6'h30, 6'h28, 6'h2C, 6'h2A, 6'h2B};
    tbl[0] = '{4'b0001, {6'h00, 6'h00, 6'h00, 6'h2A}, 1, {2'd0, 2'd0, 2'd0, 2'd0}, {6'h00, 6'h00, 6'h00, 6'h2A}};
    tbl[1] = '{4'b1010, {6'h3F, 6'h00, 6'h05, 6'h00}, 2, {2'd0, 2'd0, 2'd3, 2'd1}, {6'h00, 6'h00, 6'h3F, 6'h05}};
    tbl[2] = '{4'b1111, {6'h20, 6'h15, 6'h3F, 6'h00}, 4, {2'd3, 2'd2, 2'd1, 2'd0}, {6'h20, 6'h15, 6'h3F, 6'h00}};
    tbl[3] = '{4'b0100, {6'h00, 6'h01, 6'h00, 6'h00}, 1, {2'd0, 2'd0, 2'd0, 2'd2}, {6'h00, 6'h00, 6'h00, 6'h01}};
    tbl[4] = '{4'b0000, {6'h00, 6'h00, 6'h00, 6'h00}, 0, {2'd0, 2'd0, 2'd0, 2'd0}, {6'h00, 6'h00, 6'h00, 6'h00}};

    bus0.start_i = 0; bus0.continuous_i = 0; bus0.ch_en_i = '0;
    bus1.start_i = 0; bus1.continuous_i = 0; bus1.ch_en_i = '0;
    vin = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("rst");
    check("rst_busy1", bus1.busy_o, 0);
    rst_n = 1'b1;

    // Binary-search trace on channel 0, Vin=0x2A
    vin = tbl[0].vin;
    bus0.ch_en_i = 4'b0001;
    pulse_start0();
    check("seq_select_busy", bus0.busy_o, 1);
    check("seq_select_sample", bus0.sample_o, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("seq_sample%0d", i), bus0.sample_o, 1);
      check($sformatf("seq_sample_dac%0d", i), bus0.dac_o, 0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("seq_dac%0d", i), bus0.dac_o, dseq[i]);
      check($sformatf("seq_conv_sample%0d", i), bus0.sample_o, 0);
    end
    @(negedge clk);
    check("seq_accum_valid", bus0.valid_o, 0);
    @(negedge clk);
    check("seq_done_valid", bus0.valid_o, 1);
    check("seq_done_eoc", bus0.eoc_o, 1);
    check("seq_done_res", bus0.result_o, 6'h2A);
    check("seq_done_ch", bus0.result_ch_o, 0);
    @(negedge clk);
    check("seq_idle_busy", bus0.busy_o, 0);
    check("seq_idle_valid", bus0.valid_o, 0);
    check("seq_res_hold", bus0.result_o, 6'h2A);

    for (int k = 0; k < 5; k++) run_vec(k);

    // Continuous scan: three sweeps, mask/start changes ignored mid-sweep
    vin = {6'h00, 6'h00, 6'h22, 6'h11};
    bus0.ch_en_i = 4'b0011;
    bus0.continuous_i = 1'b1;
    pulse_start0();
    bus0.ch_en_i = 4'b1111;
    nv = 0; neoc = 0; cyc = 0; fin = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk); cyc++;
      bus0.start_i = 1'b0;
      if (bus0.valid_o) begin
        check($sformatf("cont_ch%0d", nv), bus0.result_ch_o, nv % 2);
        check($sformatf("cont_res%0d", nv), bus0.result_o, (nv % 2) ? 6'h22 : 6'h11);
        check($sformatf("cont_eoc%0d", nv), bus0.eoc_o, nv % 2);
        if (bus0.eoc_o) neoc++;
        if (nv == 1) bus0.start_i = 1'b1;
        if (nv == 4) bus0.continuous_i = 1'b0;
        if (bus0.eoc_o && nv >= 5) fin = 1;
        nv++;
      end
    end
    bus0.start_i = 1'b0;
    check("cont_nvalid", nv, 6);
    check("cont_neoc", neoc, 3);
    @(negedge clk);
    check("cont_idle_busy", bus0.busy_o, 0);
    nidle = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus0.busy_o || bus0.valid_o) nidle++;
    end
    check("cont_stays_idle", nidle, 0);
    bus0.ch_en_i = 4'b0001;

    // Oversampling: 10,11,10,11 -> 42>>2 = 10
    bus1.ch_en_i = 4'b0001;
    @(negedge clk); bus1.start_i = 1'b1;
    @(negedge clk); bus1.start_i = 1'b0;
    nv = 0; cyc = 0; first = 0; fin = 0;
    while (!fin && cyc < 200) begin
      @(negedge clk); cyc++;
      if (bus1.valid_o) begin
        if (nv == 0) first = cyc;
        check("avg_res", bus1.result_o, 10);
        check("avg_ch", bus1.result_ch_o, 0);
        check("avg_eoc", bus1.eoc_o, 1);
        if (bus1.eoc_o) fin = 1;
        nv++;
      end
    end
    check("avg_nvalid", nv, 1);
    check("avg_latency", first + 1, 38);
    check("avg_conversions", conv1, 4);

    // Reset during CONVERT aborts without a result
    vin = tbl[0].vin;
    bus0.ch_en_i = 4'b0001;
    pulse_start0();
    repeat (3) @(negedge clk);
    check("abort_in_convert_dac", bus0.dac_o, 6'h20);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("abort");
    rst_n = 1'b1;
    nidle = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus0.valid_o || bus0.busy_o) nidle++;
    end
    check("abort_no_valid", nidle, 0);
    run_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
